// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and bit-period helper for the UART transmitter.
package uart_pkg;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; bit_tick marks the last clk of each bit period.
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int W   = $clog2(CPB);
  logic [W-1:0] cnt;
  assign bit_tick = cnt == W'(CPB - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else      cnt <= (clear || bit_tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with async active-low reset rst.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_tx,
  input  logic [7:0] data_tx,
  output logic       tx_done,
  output logic       tx_out
);
  state_t     state;
  logic [7:0] shreg;
  logic [2:0] idx;
  logic       bit_tick;
  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .bit_tick (bit_tick)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      tx_out  <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: if (start_tx) begin
          state  <= START;
          shreg  <= data_tx;
          tx_out <= 1'b0;
        end
        START: if (bit_tick) begin
          state  <= DATA;
          tx_out <= shreg[0];
        end
        DATA: if (bit_tick) begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state  <= PARITY;
            tx_out <= ^shreg;
`else
            state  <= STOP;
            tx_out <= 1'b1;
`endif
          end else tx_out <= shreg[idx + 3'd1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_tick) begin
          state  <= STOP;
          tx_out <= 1'b1;
        end
`endif
        // a held start_tx chains the next frame straight out of the stop bit
        STOP: if (bit_tick) begin
          tx_done <= 1'b1;
          if (start_tx) begin
            state  <= START;
            shreg  <= data_tx;
            tx_out <= 1'b0;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of uart_tx against a line-level model.
module tb_uart_tx;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic [7:0] d;
    int         hold;
    logic [7:0] chg;
    logic [9:0] pat;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start_tx = 1'b0;
  logic [7:0] data_tx = '0;
  logic tx_done, tx_out;
  logic start_d = 1'b0;
  logic [7:0] data_d = 8'hFF;
  logic tx_done_d, tx_out_d;
  int checks = 0, failures = 0;
  vec_t tbl[5];
  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk(clk), .rst(rst), .start_tx(start_tx), .data_tx(data_tx),
    .tx_done(tx_done), .tx_out(tx_out)
  );
  uart_tx u_def (
    .clk(clk), .rst(rst), .start_tx(start_d), .data_tx(data_d),
    .tx_done(tx_done_d), .tx_out(tx_out_d)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // line bits in transmission order: start, data LSB first, stop
  function automatic logic [9:0] model_pat(input logic [7:0] d);
    logic [9:0] p;
    p[0] = 1'b0;
    for (int i = 0; i < 8; i++) p[i+1] = logic'((int'(d) / (2 ** i)) % 2);
    p[9] = 1'b1;
    return p;
  endfunction
  function automatic logic exp_line(input logic [9:0] pat, input logic [7:0] d, input int b);
    if (b < 9) return pat[b];
    if (PAR && b == 9) return logic'($countones(d) % 2);
    return pat[9];
  endfunction
  task automatic run_frame(input string name, input logic [7:0] d, input logic [9:0] pat,
                           input int hold, input logic [7:0] chg, input bit keep, input int k0);
    if (k0 == 0) begin
      data_tx = d;
      start_tx = 1'b1;
    end
    for (int k = k0; k < NB * CPB; k++) begin
      @(negedge clk);
      chk({name, "_line"}, tx_out, exp_line(pat, d, k / CPB));
      chk({name, "_done_low"}, tx_done, 1'b0);
      if (k + 1 == hold && !keep) start_tx = 1'b0;
      if (k == 3 * CPB) data_tx = chg;
    end
    @(negedge clk);
    chk({name, "_done"}, tx_done, 1'b1);
    chk({name, "_next"}, tx_out, keep ? 1'b0 : 1'b1);
  endtask
  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_line"}, tx_out, 1'b1);
      chk({name, "_done"}, tx_done, 1'b0);
    end
  endtask
  initial begin
    int n;
    logic [7:0] rd;
    tbl[0] = '{d: 8'h55, hold: 5, chg: 8'h55, pat: 10'h2AA};
    tbl[1] = '{d: 8'hA3, hold: 2, chg: 8'hFF, pat: 10'h346};
    tbl[2] = '{d: 8'h07, hold: 1, chg: 8'h00, pat: 10'h20E};
    tbl[3] = '{d: 8'hFF, hold: 3, chg: 8'h00, pat: 10'h3FE};
    tbl[4] = '{d: 8'h00, hold: 4, chg: 8'hFF, pat: 10'h200};
    repeat (2) begin
      @(negedge clk);
      chk("rst_line", tx_out, 1'b1);
      chk("rst_done", tx_done, 1'b0);
    end
    rst = 1'b1;
    idle_check("post_rst", 5);
    foreach (tbl[i]) begin
      run_frame("vec", tbl[i].d, tbl[i].pat, tbl[i].hold, tbl[i].chg, 1'b0, 0);
      idle_check("vec_idle", 12);
    end
    run_frame("b2b_first", 8'h00, model_pat(8'h00), 0, 8'hFF, 1'b1, 0);
    run_frame("b2b_second", 8'hFF, model_pat(8'hFF), 3, 8'hFF, 1'b0, 1);
    idle_check("b2b_idle", 5);
    repeat (8) begin
      rd = 8'($urandom);
      run_frame("rnd", rd, model_pat(rd), int'($urandom_range(1, 4)), 8'($urandom), 1'b0, 0);
      idle_check("rnd_idle", 2);
    end
    data_tx = 8'h55;
    start_tx = 1'b1;
    @(negedge clk);
    start_tx = 1'b0;
    repeat (4 * CPB + 1) @(negedge clk);
    chk("pre_abort_bit3", tx_out, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("abort_async_line", tx_out, 1'b1);
    chk("abort_async_done", tx_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle_check("abort_idle", 3 * CPB);
    run_frame("after_abort", 8'h55, 10'h2AA, 2, 8'h00, 1'b0, 0);
    idle_check("after_abort_idle", 3);
    start_d = 1'b1;
    n = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i == 0) start_d = 1'b0;
      if (tx_out_d) break;
      n++;
    end
    chk_int("default_bit_period", n, 5208);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
